// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one combinational ADD unit between two requesters.
// The operands are registered, and the result is returned through a valid/ready handshake.
module add_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_overflow,
  input  logic             add_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_overflow,
  output logic             rsp_carry,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_owner;
  logic             r_last;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;
  logic             r_cry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_req_any;
  logic             w_pick1;

  assign w_req_any = req0 | req1;
  // When both requesters are asking, the grant goes to the one that did not win last.
  assign w_pick1   = req1 & (~req0 | ~r_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req_any) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_cry       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_a     <= w_pick1 ? a1 : a0;
            r_b     <= w_pick1 ? b1 : b0;
            r_owner <= w_pick1;
            r_last  <= w_pick1;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
          end
        end
        EXEC: begin
          r_sum       <= add_sum;
          r_ovf       <= add_overflow;
          r_cry       <= add_carry;
          r_rsp_id    <= r_owner;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt0         = r_gnt0;
  assign gnt1         = r_gnt1;
  assign add_a        = r_a;
  assign add_b        = r_b;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_sum      = r_sum;
  assign rsp_overflow = r_ovf;
  assign rsp_carry    = r_cry;
  assign busy         = (r_state != IDLE);
  assign op_count     = r_cnt;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter, with a behavioural 16-bit adder standing in for the shared ADD unit.
module tb_add_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, rsp_ready = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, rsp_valid, rsp_id, rsp_overflow, rsp_carry, busy;
  logic [15:0] add_a, add_b, add_sum, rsp_sum;
  logic        add_overflow, add_carry;
  logic [3:0]  op_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_cnt = '0;

  always #5 clk = ~clk;

  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};
  assign add_overflow = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);

  add_arbiter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .add_overflow(add_overflow), .add_carry(add_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
    .busy(busy), .op_count(op_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_gnt0"}, 16'(gnt0), 16'h0);
    check({tag, "_gnt1"}, 16'(gnt1), 16'h0);
    check({tag, "_valid"}, 16'(rsp_valid), 16'h0);
    check({tag, "_id"}, 16'(rsp_id), 16'h0);
    check({tag, "_sum"}, rsp_sum, 16'h0);
    check({tag, "_flags"}, 16'({rsp_overflow, rsp_carry}), 16'h0);
    check({tag, "_busy"}, 16'(busy), 16'h0);
    check({tag, "_add_a"}, add_a, 16'h0);
    check({tag, "_add_b"}, add_b, 16'h0);
    check({tag, "_cnt"}, 16'(op_count), 16'h0);
  endtask

  // One complete operation from a single requester, with the response accepted immediately.
  task automatic do_op(input logic who, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] esum, input logic ev, input logic ec);
    if (who) begin req1 = 1'b1; a1 = a; b1 = b; end
    else     begin req0 = 1'b1; a0 = a; b0 = b; end
    step();
    check("op_gnt0", 16'(gnt0), 16'(!who));
    check("op_gnt1", 16'(gnt1), 16'(who));
    check("op_busy", 16'(busy), 16'h1);
    check("op_add_a", add_a, a);
    check("op_add_b", add_b, b);
    check("op_valid_early", 16'(rsp_valid), 16'h0);
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("op_gnt_clear", 16'({gnt0, gnt1}), 16'h0);
    check("op_valid", 16'(rsp_valid), 16'h1);
    check("op_id", 16'(rsp_id), 16'(who));
    check("op_sum", rsp_sum, esum);
    check("op_ovf", 16'(rsp_overflow), 16'(ev));
    check("op_carry", 16'(rsp_carry), 16'(ec));
    rsp_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 4'd1;
    check("op_valid_drop", 16'(rsp_valid), 16'h0);
    check("op_busy_drop", 16'(busy), 16'h0);
    check("op_count", 16'(op_count), 16'(exp_cnt));
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] held;
    logic exp1;

    // Reset state
    rst = 1'b1; step(); step();
    check_idle_zero("reset");
    rst = 1'b0;
    step();
    check("idle_nogrant", 16'({gnt0, gnt1, busy}), 16'h0);

    // Single op and flag cases
    do_op(1'b0, 16'h0002, 16'h0004, 16'h0006, 1'b0, 1'b0);
    do_op(1'b1, 16'h4000, 16'h4000, 16'h8000, 1'b1, 1'b0);
    do_op(1'b0, 16'hC000, 16'h4000, 16'h0000, 1'b0, 1'b1);
    do_op(1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    check("hold_add_a", add_a, 16'h8000);

    // Round-robin with both requests held; the reset makes requester 0 win first
    rst = 1'b1; step(); rst = 1'b0; exp_cnt = '0;
    req0 = 1'b1; a0 = 16'h0100; b0 = 16'h0001;
    req1 = 1'b1; a1 = 16'h0200; b1 = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      exp1 = (i % 2 == 1);
      step();
      check("rr_gnt0", 16'(gnt0), 16'(!exp1));
      check("rr_gnt1", 16'(gnt1), 16'(exp1));
      step();
      check("rr_id", 16'(rsp_id), 16'(exp1));
      check("rr_sum", rsp_sum, exp1 ? 16'h0202 : 16'h0101);
      rsp_ready = 1'b1;
      step();
      exp_cnt = exp_cnt + 4'd1;
      check("rr_cnt", 16'(op_count), 16'(exp_cnt));
      rsp_ready = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;

    // Backpressure with requester 1 pending
    req0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111;
    step();
    check("bp_gnt0", 16'(gnt0), 16'h1);
    req0 = 1'b0; req1 = 1'b1; a1 = 16'h0001; b1 = 16'h0001;
    step();
    held = rsp_sum;
    check("bp_sum", rsp_sum, 16'h2345);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_hold", 16'(rsp_valid), 16'h1);
      check("bp_sum_hold", rsp_sum, held);
      check("bp_no_gnt", 16'({gnt0, gnt1}), 16'h0);
    end
    rsp_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 4'd1;
    check("bp_release", 16'({rsp_valid, busy, gnt1}), 16'h0);
    rsp_ready = 1'b0;
    step();
    check("bp_gnt1_next", 16'({gnt0, gnt1}), 16'h1);
    req1 = 1'b0;
    step();
    check("bp_sum1", rsp_sum, 16'h0002);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    check("bp_cnt", 16'(op_count), 16'(exp_cnt));

    // Reset during EXEC, then during RESP
    req0 = 1'b1; a0 = 16'h0F00; b0 = 16'h00F0;
    step();
    check("mid_exec_busy", 16'(busy), 16'h1);
    rst = 1'b1; req0 = 1'b0;
    step();
    check_idle_zero("rst_exec");
    rst = 1'b0;
    step();
    check("rst_exec_novalid", 16'(rsp_valid), 16'h0);
    req1 = 1'b1; a1 = 16'h0003; b1 = 16'h0004;
    step(); req1 = 1'b0;
    step();
    check("mid_resp_valid", 16'(rsp_valid), 16'h1);
    rst = 1'b1;
    step();
    check_idle_zero("rst_resp");
    rst = 1'b0;
    req0 = 1'b1; a0 = 16'h0011; b0 = 16'h0022;
    req1 = 1'b1; a1 = 16'h0033; b1 = 16'h0044;
    step();
    check("post_rst_gnt", 16'({gnt0, gnt1}), 16'h2);
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("post_rst_sum", rsp_sum, 16'h0033);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    check("post_rst_cnt", 16'(op_count), 16'h1);

    // Counter wrap after 16 accepted responses
    rst = 1'b1; step(); rst = 1'b0; exp_cnt = '0;
    for (int i = 0; i < 16; i++)
      do_op(1'b1, 16'(i), 16'h0010, 16'(i + 16), 1'b0, 1'b0);
    check("wrap_zero", 16'(op_count), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Shares one combinational 16-bit ADD unit between two requesters (for example the ALU issue path and the address/PC-increment path).
- Arbitrates round-robin and drives the adder operands from registered copies.
- Captures sum, overflow and carry into a result register.
- Returns the result with a valid/ready handshake tagged by requester ID.
- Sits between the requesters and the shared ADD instance in the processor datapath.

Parameters:
WIDTH, 16, operand/sum width; must match the ADD instance.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
req0  input  1  requester 0 request; held high with operands stable until gnt0
a0  input  WIDTH  requester 0 operand a
b0  input  WIDTH  requester 0 operand b
gnt0  output  1  one-cycle acknowledge: requester 0 operands captured
req1  input  1  requester 1 request
a1  input  WIDTH  requester 1 operand a
b1  input  WIDTH  requester 1 operand b
gnt1  output  1  one-cycle acknowledge for requester 1
add_a  output  WIDTH  to shared ADD .a
add_b  output  WIDTH  to shared ADD .b
add_sum  input  WIDTH  from ADD .sum
add_overflow  input  1  from ADD .overflow (signed overflow)
add_carry  input  1  from ADD .carry (unsigned carry-out)
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_id  output  1  requester that owns the result
rsp_sum  output  WIDTH  registered sum
rsp_overflow  output  1  registered overflow flag
rsp_carry  output  1  registered carry flag
busy  output  1  high in any state other than IDLE
op_count  output  CNT_W  number of accepted responses, wraps modulo 2^CNT_W

Behaviour:
Reset (rst=1 at a clock edge) has priority over every other event, including mid-operation:
- State goes to IDLE.
- gnt0, gnt1, rsp_valid, rsp_id, rsp_sum, rsp_overflow, rsp_carry, op_count, busy all 0.
- Operand registers (add_a/add_b) go to 0.
- last_grant pointer goes to 1, so requester 0 wins the first contest.
- Any in-flight operation is discarded; no response is produced for it.

FSM states: IDLE, EXEC, RESP.

IDLE:
- No request: stay in IDLE; gnt0=gnt1=0.
- Only reqX high: latch aX/bX into operand registers, record owner=X, pulse gntX for exactly one cycle (registered, asserted the cycle after the sampling edge), go to EXEC, set last_grant=X.
- Both high: grant the requester other than last_grant, with the same actions as above. The loser keeps waiting and is not granted in the same transaction.

EXEC (exactly 1 cycle):
- add_a/add_b are stable from the operand registers; the adder settles combinationally.
- On the edge: capture add_sum, add_overflow and add_carry into the rsp_* registers; rsp_id=owner; rsp_valid=1; go to RESP.

RESP:
- rsp_valid=1 and all rsp_* fields are held stable until the handshake completes.
- rsp_valid && rsp_ready at an edge: rsp_valid=0, op_count increments (wraps from all-ones to 0), go to IDLE.
- rsp_ready low: stay in RESP indefinitely; new requests are not granted (no buffering).

Handshake and timing rules:
- A request seen in the same cycle the response handshake completes is not granted until the next cycle (IDLE evaluates it).
- Minimum issue interval is 3 cycles per operation. Latency from grant edge to rsp_valid is 1 cycle.
- Requesters must not change aX/bX while reqX=1 and gntX=0. After gntX they may drop reqX or present a new operand pair.
- gnt pulses never occur outside the IDLE->EXEC transition. gnt0 and gnt1 are never both high.
- Arithmetic is the ADD unit's: sum = (a+b) mod 2^WIDTH, carry = unsigned carry-out, overflow = signed overflow. The arbiter passes these through unmodified.
- add_a/add_b hold the last operands while in RESP/IDLE (no toggling until the next grant).

Test Plan:
1. Single op: reset, then req0=1, a0=0x0002, b0=0x0004 -> gnt0 one pulse; two cycles later rsp_valid=1, rsp_id=0, rsp_sum=0x0006, V=0, C=0; rsp_ready=1 -> op_count=1, busy=0.
2. Flags: req1 with 0x4000+0x4000 -> rsp_sum=0x8000, V=1, C=0, rsp_id=1. Then req0 with 0xC000+0x4000 -> 0x0000, V=0, C=1. Then 0x8000+0x8000 -> 0x0000, V=1, C=1.
3. Round-robin: req0 and req1 held high continuously with distinct operands, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence matches; never both gnt high.
4. Backpressure: complete an op with rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_* stable, no new gnt despite pending req1; rsp_ready=1 -> IDLE, then gnt1 the following cycle.
5. Reset mid-op: assert rst during EXEC and during RESP -> next cycle all outputs 0, no rsp_valid pulse. First post-reset contest with both req high grants requester 0.
6. Counter wrap (CNT_W=4): complete 16 ops -> op_count returns to 0.
